btn_conditioner: RTL

- Sits between the raw board buttons and the scene logic.
- Synchronises, debounces and edge-detects the nine push buttons.
- Latches press events per video frame, so the scene sees each press exactly once in its frame-rate update, regardless of pixel position.
- Instantiated in the top level, fed by the raw pins and by the frame-start strobe from the VGA timing counters. Its outputs drive the scene's button inputs.

---
 rtl/btn_conditioner_if.sv | 27 ++
 rtl/btn_conditioner.sv | 127 ++++++++++++
 2 files changed

// File: rtl/btn_conditioner_if.sv
// Button conditioner port bundle: raw pins and frame strobe in, conditioned button vectors out.
// Strobe semantics: frame_start and btn_press are single-cycle pulses with no back-pressure; btn_level and btn_frame are levels.
interface btn_conditioner_if #(
    parameter int N_BTN = 9
);
    logic [N_BTN-1:0] btn_raw;
    logic             frame_start;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_frame;

    modport master (
        output btn_raw,
        output frame_start,
        input  btn_level,
        input  btn_press,
        input  btn_frame
    );

    modport slave (
        input  btn_raw,
        input  frame_start,
        output btn_level,
        output btn_press,
        output btn_frame
    );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronise, debounce, edge-detect and per-frame latch N_BTN push buttons.
// Optional auto-repeat of held buttons into btn_frame is compiled in with `define BTN_REPEAT_EN.
module btn_conditioner #(
    parameter int N_BTN           = 9,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_PERIOD   = 6
) (
    input logic              clk,
    input logic              rst_n,
    btn_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] lvl;
    logic [N_BTN-1:0] lvl_d;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] frame_q;
    logic [N_BTN-1:0] rpt_hit;

    // Elaboration-time guards on the parameter set.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("btn_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("btn_conditioner: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             lvl_r;

        // Any sample agreeing with the stable level restarts the run; the count stops at the flip.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                lvl_r <= 1'b0;
            end else if (sync2[i] == lvl_r) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                lvl_r <= sync2[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign lvl[i] = lvl_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d   <= '0;
            press_q <= '0;
        end else begin
            lvl_d   <= lvl;
            press_q <= lvl & ~lvl_d;
        end
    end

    // A press landing on the frame strobe seeds the next frame's pending set instead of this one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            frame_q <= '0;
        end else if (bus.frame_start) begin
            frame_q <= pend;
            pend    <= press_q | rpt_hit;
        end else begin
            pend <= pend | press_q;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    for (genvar i = 0; i < N_BTN; i++) begin : g_rpt
        logic [RPT_W-1:0] rpt;

        // rpt counts held frames; reaching the delay fires a repeat and rewinds by one period.
        assign rpt_hit[i] = lvl[i] & (rpt == RPT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rpt <= '0;
            end else if (press_q[i]) begin
                rpt <= '0;
            end else if (bus.frame_start) begin
                if (!lvl[i]) begin
                    rpt <= '0;
                end else if (rpt_hit[i]) begin
                    rpt <= RPT_RELOAD;
                end else begin
                    rpt <= rpt + 1'b1;
                end
            end
        end
    end
`else
    assign rpt_hit = '0;
`endif

    assign bus.btn_level = lvl;
    assign bus.btn_press = press_q;
    assign bus.btn_frame = frame_q;

endmodule
